// File: rtl/oblivious_transfer_sender.sv
// Sender side of a 1-out-of-2 RSA oblivious transfer, byte-stream framed.
// It sends N, e, x0, x1, receives the blinded value v, computes
// k_i = (v - x_i)^d mod N with a serial square-and-multiply engine, then
// sends m_i' = (m_i + k_i) mod N for i = 0, 1.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             one-cycle pulse; latches the operands when idle
//   n_in .. m1_in     modulus, exponents, random values, messages
//   tx_valid/ready/data   outgoing byte stream (registered)
//   rx_valid/ready/data   incoming byte stream
//   busy, done        status (busy outside IDLE/DONE, done in DONE)
// Words travel as 4 bytes, least significant byte first.
module oblivious_transfer_sender #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] n_in,
    input  logic [W-1:0] e_in,
    input  logic [W-1:0] d_in,
    input  logic [W-1:0] x0_in,
    input  logic [W-1:0] x1_in,
    input  logic [W-1:0] m0_in,
    input  logic [W-1:0] m1_in,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic [7:0]   rx_data,
    output logic         busy,
    output logic         done
);

    typedef enum logic [3:0] {
        IDLE, TX1, RX, SUB0, EXP0, ADD0, SUB1, EXP1, ADD1, TX2, DONE
    } state_t;

    state_t state, state_next;

    logic [W-1:0] n_r, e_r, d_r, x0_r, x1_r, m0_r, m1_r;
    logic [W-1:0] v_r, t_r, r_r, m0p_r, m1p_r;
    logic [W+1:0] acc_r;
    logic [3:0]   byte_cnt;
    logic [4:0]   it_cnt;
    logic [4:0]   bit_idx;
    logic         mul_ph;     // 0: squaring step, 1: multiply-by-t step

    logic tx_fire, rx_fire, mm_last, exp_last;
    assign tx_fire  = tx_valid && tx_ready;
    assign rx_fire  = rx_valid && rx_ready;
    assign mm_last  = (it_cnt == 5'd31);
    assign exp_last = mul_ph && mm_last && (bit_idx == 5'd0);

    function automatic logic [7:0] byte_of(input logic [W-1:0] w, input logic [1:0] b);
        return w[{b, 3'b000} +: 8];
    endfunction

    // Next byte to present after a transfer in TX1 / TX2.
    logic [3:0]   nxt_cnt;
    logic [W-1:0] tx1_word, tx2_word;
    assign nxt_cnt  = byte_cnt + 4'd1;
    assign tx2_word = nxt_cnt[2] ? m1p_r : m0p_r;
    always_comb begin
        tx1_word = n_r;
        case (nxt_cnt[3:2])
            2'd0: tx1_word = n_r;
            2'd1: tx1_word = e_r;
            2'd2: tx1_word = x0_r;
            2'd3: tx1_word = x1_r;
            default: tx1_word = n_r;
        endcase
    end

    // Interleaved shift-add modmul step: acc = 2*acc + bit*r, each stage
    // reduced by one conditional subtract. The multiplicand is always r;
    // the multiplier is r (square) or t (multiply), scanned MSB first, so
    // bit index 31 - it_cnt is simply ~it_cnt.
    logic [W-1:0] mult_op;
    logic         mm_bit;
    logic [W+1:0] n_ext, dbl, dbl_red, sum_mm, add_red;
    assign mult_op = mul_ph ? t_r : r_r;
    assign mm_bit  = mult_op[~it_cnt];
    assign n_ext   = {2'b00, n_r};
    assign dbl     = acc_r << 1;
    assign dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
    assign sum_mm  = dbl_red + (mm_bit ? {2'b00, r_r} : '0);
    assign add_red = (sum_mm >= n_ext) ? sum_mm - n_ext : sum_mm;

    // t = v - x_i (+N on borrow). The true result is below N, so the low
    // W bits of the wrapped difference are exact.
    logic [W-1:0] sub_x, t_next;
    assign sub_x  = (state == SUB0) ? x0_r : x1_r;
    assign t_next = (v_r >= sub_x) ? v_r - sub_x : v_r - sub_x + n_r;

    // m' = m_i + r in W+1 bits, minus N when the sum reaches N.
    logic [W-1:0] m_sel, m_res;
    logic [W:0]   m_sum;
    assign m_sel = (state == ADD0) ? m0_r : m1_r;
    assign m_sum = {1'b0, m_sel} + {1'b0, r_r};
    assign m_res = (m_sum >= {1'b0, n_r}) ? m_sum[W-1:0] - n_r : m_sum[W-1:0];

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = TX1;
            TX1:  if (tx_fire && byte_cnt == 4'd15) state_next = RX;
            RX:   if (rx_fire && byte_cnt == 4'd3) state_next = SUB0;
            SUB0: state_next = EXP0;
            EXP0: if (exp_last) state_next = ADD0;
            ADD0: state_next = SUB1;
            SUB1: state_next = EXP1;
            EXP1: if (exp_last) state_next = ADD1;
            ADD1: state_next = TX2;
            TX2:  if (tx_fire && byte_cnt == 4'd7) state_next = DONE;
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_r <= '0; e_r <= '0; d_r <= '0; x0_r <= '0; x1_r <= '0;
            m0_r <= '0; m1_r <= '0; v_r <= '0; t_r <= '0; r_r <= '0;
            m0p_r <= '0; m1p_r <= '0; acc_r <= '0;
            byte_cnt <= '0; it_cnt <= '0; bit_idx <= '0; mul_ph <= 1'b0;
            tx_valid <= 1'b0; tx_data <= '0; rx_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    n_r <= n_in; e_r <= e_in; d_r <= d_in;
                    x0_r <= x0_in; x1_r <= x1_in; m0_r <= m0_in; m1_r <= m1_in;
                    tx_valid <= 1'b1;
                    tx_data  <= n_in[7:0];
                    byte_cnt <= '0;
                end
                TX1: if (tx_fire) begin
                    if (byte_cnt == 4'd15) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        rx_ready <= 1'b1;
                        byte_cnt <= '0;
                    end else begin
                        byte_cnt <= nxt_cnt;
                        tx_data  <= byte_of(tx1_word, nxt_cnt[1:0]);
                    end
                end
                RX: if (rx_fire) begin
                    v_r <= {rx_data, v_r[W-1:8]};
                    if (byte_cnt == 4'd3) begin
                        rx_ready <= 1'b0;
                        byte_cnt <= '0;
                    end else begin
                        byte_cnt <= nxt_cnt;
                    end
                end
                SUB0, SUB1: begin
                    t_r     <= t_next;
                    r_r     <= {{(W-1){1'b0}}, 1'b1};
                    acc_r   <= '0;
                    it_cnt  <= '0;
                    bit_idx <= 5'd31;
                    mul_ph  <= 1'b0;
                end
                EXP0, EXP1: begin
                    it_cnt <= it_cnt + 5'd1;
                    if (mm_last) begin
                        acc_r <= '0;
                        if (!mul_ph) begin
                            r_r    <= add_red[W-1:0];
                            mul_ph <= 1'b1;
                        end else begin
                            // The multiply always runs so both exponentiations
                            // take the same time; its result is kept only for d[j]=1.
                            if (d_r[bit_idx]) r_r <= add_red[W-1:0];
                            mul_ph  <= 1'b0;
                            bit_idx <= bit_idx - 5'd1;
                        end
                    end else begin
                        acc_r <= add_red;
                    end
                end
                ADD0: m0p_r <= m_res;
                ADD1: begin
                    m1p_r    <= m_res;
                    tx_valid <= 1'b1;
                    tx_data  <= m0p_r[7:0];
                    byte_cnt <= '0;
                end
                TX2: if (tx_fire) begin
                    if (byte_cnt == 4'd7) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                    end else begin
                        byte_cnt <= nxt_cnt;
                        tx_data  <= byte_of(tx2_word, nxt_cnt[1:0]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oblivious_transfer_sender.sv
// Directed bench for oblivious_transfer_sender: a table of operand sets with
// expected m0'/m1' (hand values where easy, otherwise a plain arithmetic
// model), each run as a full protocol exchange, plus reset and stray-start
// sequences.
module tb_oblivious_transfer_sender;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] n_in = '0, e_in = '0, d_in = '0, x0_in = '0, x1_in = '0, m0_in = '0, m1_in = '0;
    logic        tx_valid, tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        rx_valid = 1'b0, rx_ready;
    logic [7:0]  rx_data = '0;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    oblivious_transfer_sender #(.W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .n_in(n_in), .e_in(e_in), .d_in(d_in), .x0_in(x0_in), .x1_in(x1_in),
        .m0_in(m0_in), .m1_in(m1_in),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] n, e, d, x0, x1, m0, m1, v, m0p, m1p;
        bit          rnd;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] mulmod(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
        longint unsigned aa, bb, nn;
        aa = a; bb = b; nn = n;
        return 32'((aa * bb) % nn);
    endfunction

    // Right-to-left binary exponentiation.
    function automatic logic [31:0] powmod(input logic [31:0] t, input logic [31:0] d, input logic [31:0] n);
        logic [31:0] res, base;
        res = 32'd1; base = t;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) res = mulmod(res, base, n);
            base = mulmod(base, base, n);
        end
        return res;
    endfunction

    function automatic logic [31:0] model_m(input logic [31:0] m, input logic [31:0] v, input logic [31:0] x,
                                            input logic [31:0] d, input logic [31:0] n);
        longint unsigned t, s;
        t = (v >= x) ? longint'(v) - longint'(x) : longint'(v) + longint'(n) - longint'(x);
        s = (longint'(m) + longint'(powmod(32'(t), d, n))) % longint'(n);
        return 32'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear before any edge.
    task automatic mid_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, " rst tx_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, " rst tx_data"},  {24'd0, tx_data},  32'd0);
        chk({tag, " rst rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, " rst busy"},     {31'd0, busy},     32'd0);
        chk({tag, " rst done"},     {31'd0, done},     32'd0);
        tx_ready = 1'b0; rx_valid = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // abort_mode: 0 run to DONE, 1 reset inside EXP0, 2 reset inside TX2.
    task automatic run_vec(input vec_t vv, input int abort_mode, input bit poke_start, input string tag);
        logic [7:0] expb[24];
        logic [7:0] got[$];
        int   rx_idx, after_rx;
        bit   stall, poked;
        logic [7:0] stall_data;
        for (int w = 0; w < 4; w++) begin
            expb[w]      = vv.n[8*w +: 8];
            expb[4 + w]  = vv.e[8*w +: 8];
            expb[8 + w]  = vv.x0[8*w +: 8];
            expb[12 + w] = vv.x1[8*w +: 8];
            expb[16 + w] = vv.m0p[8*w +: 8];
            expb[20 + w] = vv.m1p[8*w +: 8];
        end
        rx_idx = 0; after_rx = 0; stall = 1'b0; poked = 1'b0; stall_data = '0;

        @(negedge clk);
        reset = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; start = 1'b0;
        #1;
        chk({tag, " reset tx_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, " reset done"},     {31'd0, done},     32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_in = vv.n; e_in = vv.e; d_in = vv.d; x0_in = vv.x0; x1_in = vv.x1;
        m0_in = vv.m0; m1_in = vv.m1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            if (stall) begin
                chk({tag, " hold tx_valid"}, {31'd0, tx_valid}, 32'd1);
                chk({tag, " hold tx_data"},  {24'd0, tx_data},  {24'd0, stall_data});
            end
            start = 1'b0;
            tx_ready = vv.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke_start && rx_ready && !poked) begin
                start = 1'b1;
                n_in = 32'hDEAD_BEEF; d_in = 32'h0; x0_in = 32'h1234; m0_in = 32'h55;
                poked = 1'b1;
            end
            if (rx_ready) begin
                if (rx_idx < 4 && (!vv.rnd || $urandom_range(0, 2) != 0)) begin
                    rx_valid = 1'b1;
                    rx_data  = vv.v[8*rx_idx +: 8];
                end else begin
                    rx_valid = 1'b0;
                    rx_data  = 8'hEE;
                end
            end else begin
                // Junk offered while not ready must be ignored.
                rx_valid = vv.rnd;
                rx_data  = 8'hA5;
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            stall      = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (rx_valid && rx_ready) rx_idx++;
            if (rx_idx == 4) after_rx++;
            if (abort_mode == 1 && after_rx == 300) begin
                chk({tag, " busy in exp"}, {31'd0, busy}, 32'd1);
                mid_reset({tag, " exp0"});
                return;
            end
            if (abort_mode == 2 && got.size() == 19) begin
                chk({tag, " tx2 valid"}, {31'd0, tx_valid}, 32'd1);
                mid_reset({tag, " tx2"});
                return;
            end
            @(negedge clk);
        end
        tx_ready = 1'b0; rx_valid = 1'b0;

        chk({tag, " done"},     {31'd0, done},     32'd1);
        chk({tag, " busy"},     {31'd0, busy},     32'd0);
        chk({tag, " nbytes"},   32'(got.size()),   32'd24);
        chk({tag, " rx bytes"}, 32'(rx_idx),       32'd4);
        for (int i = 0; i < 24; i++)
            chk($sformatf("%s byte%0d", tag, i), {24'd0, (i < got.size()) ? got[i] : 8'hxx}, {24'd0, expb[i]});

        // Start in DONE is ignored.
        start = 1'b1; n_in = 32'h77; @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, " done after start"},   {31'd0, done},     32'd1);
        chk({tag, " tx idle after start"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, " busy after start"},   {31'd0, busy},     32'd0);
    endtask

    initial begin
        vecs[0] = '{32'd3233, 32'd17, 32'd2753, 32'd100, 32'd200, 32'd7, 32'd42, 32'd53,
                    model_m(32'd7, 32'd53, 32'd100, 32'd2753, 32'd3233), 32'd47, 1'b0};
        vecs[1] = '{32'd3233, 32'd17, 32'd2753, 32'd100, 32'd200, 32'd7, 32'd42, 32'd100,
                    32'd7, model_m(32'd42, 32'd100, 32'd200, 32'd2753, 32'd3233), 1'b0};
        vecs[2] = vecs[0];
        vecs[2].rnd = 1'b1;
        // d = 0: k = 1 for both; m1 = N-1 wraps to 0.
        vecs[3] = '{32'd3233, 32'd17, 32'd0, 32'd5, 32'd9, 32'd10, 32'd3232, 32'd300,
                    32'd11, 32'd0, 1'b0};
        vecs[4] = '{32'hFFFF_FFFB, 32'd3, 32'h89AB_CDEF, 32'hFFFF_FF00, 32'd1, 32'hFFFF_FFFA, 32'd0,
                    32'h1234_5678,
                    model_m(32'hFFFF_FFFA, 32'h1234_5678, 32'hFFFF_FF00, 32'h89AB_CDEF, 32'hFFFF_FFFB),
                    model_m(32'd0, 32'h1234_5678, 32'd1, 32'h89AB_CDEF, 32'hFFFF_FFFB), 1'b1};

        repeat (2) @(negedge clk);
        chk("initial tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("initial tx_data",  {24'd0, tx_data},  32'd0);
        chk("initial rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("initial busy",     {31'd0, busy},     32'd0);
        chk("initial done",     {31'd0, done},     32'd0);

        run_vec(vecs[0], 0, 1'b1, "v53_poke");
        for (int k = 1; k < 5; k++)
            run_vec(vecs[k], 0, 1'b0, $sformatf("vec%0d", k));
        run_vec(vecs[0], 1, 1'b0, "abort_exp");
        run_vec(vecs[1], 0, 1'b0, "after_exp_abort");
        run_vec(vecs[4], 2, 1'b0, "abort_tx2");
        run_vec(vecs[0], 0, 1'b0, "after_tx2_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/oblivious_transfer_sender.md
Name: oblivious_transfer_sender

Overview:
Sender side of the 1-out-of-2 RSA oblivious transfer and the byte-stream peer of the OT receiver.
- Phase 1: emits N, e, x0, x1 as bytes.
- Phase 2: accepts the receiver's blinded value v.
- Phase 3: computes k_i = (v − x_i)^d mod N with an internal serial square-and-multiply engine, then m_i' = (m_i + k_i) mod N.
- Phase 4: emits m0', m1'.
Sits in the top level, cross-connected so that this block's tx drives the receiver's rx, and vice versa.

Parameters:
W, 32, operand width in bits; fixed at 32, since byte framing assumes 4 bytes per word.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; latches all operand inputs when in IDLE
n_in  in  32  RSA modulus N (N ≥ 3)
e_in  in  32  public exponent
d_in  in  32  private exponent
x0_in  in  32  random value 0 (< N)
x1_in  in  32  random value 1 (< N)
m0_in  in  32  message 0 (< N)
m1_in  in  32  message 1 (< N)
tx_valid  out  1  tx_data holds a valid byte
tx_ready  in  1  peer accepts byte
tx_data  out  8  outgoing byte
rx_valid  in  1  rx_data holds a valid byte
rx_ready  out  1  block accepts byte
rx_data  in  8  incoming byte
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; tx_valid=0, tx_data=0, rx_ready=0, busy=0, done=0; all byte and word counters and internal registers cleared. Reset mid-transfer abandons the protocol; no partial byte is re-sent.
- Handshake: a byte transfers on a rising edge where valid && ready.
  - tx_data and tx_valid are registered and change only after a transfer, or on entry to a TX state.
  - rx_data is sampled only on a transfer.
- Framing: each 32-bit word is sent or received as 4 bytes, LSB first ([7:0], [15:8], [23:16], [31:24]).
- States and transitions:
  - IDLE: start=1 → latch all inputs; go to TX1 with tx_valid=1 and tx_data=N[7:0] on the next cycle. start while not in IDLE is ignored.
  - TX1: send 16 bytes in order N, e, x0, x1. After the 16th transfer, tx_valid=0 and rx_ready=1 → RX.
  - RX: receive 4 bytes into v. After the 4th transfer, rx_ready=0 → SUB0.
  - SUB0/SUB1: t = (v ≥ x_i) ? v − x_i : v − x_i + N, computed in 33 bits; 1 cycle. Then → EXP0/EXP1.
  - EXP0/EXP1: r = t^d mod N.
    - Left-to-right scan of d, bits 31 down to 0; r starts at 1.
    - Per bit: r = r·r mod N, then if d[j]=1, r = r·t mod N.
    - Each modmul is interleaved shift-add: 32 iterations, 1 cycle each. Per iteration: acc = 2·acc mod N, then acc += operand if the multiplier bit is set, reduced mod N. acc is held in 34 bits; each reduction step is one conditional subtract of N.
    - Fixed latency: 64 modmuls plus overhead per exponentiation; both exponentiations must take the same cycle count.
    - Then → ADD0/ADD1.
  - ADD0/ADD1: m_i' = (m_i + r) computed in 33 bits, minus N if ≥ N; 1 cycle. ADD0 → SUB1; ADD1 → TX2 with tx_valid=1.
  - TX2: send 8 bytes, m0' then m1'. After the last transfer, tx_valid=0 → DONE.
  - DONE: done=1; hold until reset. start is ignored.
- Boundary cases:
  - v == x_i → t=0 → k_i=0 → m_i' = m_i.
  - d == 0 → k_i = 1.
  - tx_ready held low → tx_valid and tx_data are held stable indefinitely.
  - rx_valid while rx_ready=0 → ignored; nothing latched.
  - Operands ≥ N or N < 3 → result undefined, but the FSM must still reach DONE.
- No combinational path from any input to any output.

Test Plan:
- Setup: N=3233, e=17, d=2753, x0=100, x1=200, m0=7, m1=42; pulse start; tx_ready=1 → tx emits 16 bytes A1 0C 00 00 11 00 00 00 64 00 00 00 C8 00 00 00, then rx_ready=1.
- Receiver chose b=1, k=5: feed v=53 (35 00 00 00) → k1=5, m1'=47; check that bytes 5–8 of the final output are 2F 00 00 00; m0' must match the software model; done=1.
- Feed v=100 (= x0) → m0'=7; first output bytes 07 00 00 00.
- tx_ready toggled randomly and rx_valid gapped → identical byte sequence; tx_data stable whenever tx_valid=1 && tx_ready=0.
- Assert reset during EXP0 and during TX2 → all outputs 0 immediately (asynchronous); a new start completes correctly.
- Pulse start during RX, and again in DONE → no effect on latched operands or state.
